// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the up/down modulus counter: boundary mode constants
// and the clamped parallel-load helper.
package mod_updown_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Operands are carried at the maximum legal width (32); callers zero-extend
  // and truncate back to their own counter width.
  function automatic logic [31:0] clamp_load(input logic [31:0] d,
                                             input logic [31:0] max_val);
    return (d <= max_val) ? d : max_val;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count logic: one enabled step in the given direction,
// honouring the runtime modulus and the wrap/saturate boundary mode.
module mod_counter_next
  import mod_updown_counter_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [BITS-1:0] q,
  input  logic            up,
  input  logic [BITS-1:0] max_val,
  output logic [BITS-1:0] next_q,
  output logic            boundary
);

  localparam bit SAT = (SATURATE == MODE_SAT);

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // branches below can leave it unassigned and infer a latch.
    next_q   = q;
    boundary = 1'b0;
    if (up) begin
      if (q >= max_val) begin
        boundary = 1'b1;
        next_q   = SAT ? max_val : '0;
      end else begin
        next_q = q + 1'b1;
      end
    end else begin
      // A count above a freshly lowered bound snaps to the bound; that is a
      // correction, not a boundary event.
      if (q > max_val) begin
        next_q = max_val;
      end else if (q == '0) begin
        boundary = 1'b1;
        next_q   = SAT ? '0 : max_val;
      end else begin
        next_q = q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// General-purpose up/down counter with runtime modulus, clear/load/enable
// command priority, registered terminal-count pulse and sticky overflow.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            up,
  input  logic            clr,
  input  logic            load,
  input  logic [BITS-1:0] d,
  input  logic [BITS-1:0] max_val,
  output logic [BITS-1:0] Q,
  output logic            tc,
  output logic            ovf
);

  logic [BITS-1:0] step_q;
  logic            step_boundary;
  logic [BITS-1:0] load_q;

  mod_counter_next #(
    .BITS     (BITS),
    .SATURATE (SATURATE)
  ) u_next (
    .q        (Q),
    .up       (up),
    .max_val  (max_val),
    .next_q   (step_q),
    .boundary (step_boundary)
  );

  assign load_q = BITS'(clamp_load(32'(d), 32'(max_val)));

  // Priority per edge: clr > load > en > hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (clr) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      Q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      Q  <= load_q;
      tc <= 1'b0;
    end else if (en) begin
      Q   <= step_q;
      tc  <= step_boundary;
      ovf <= ovf | step_boundary;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised successor to the plain free-running up counter.
- Adds enable, up/down direction, synchronous clear and parallel load, and a runtime-programmable modulus.
- Selectable wrap or saturate mode; registered terminal-count pulse; sticky overflow flag.
- Used as the general-purpose timer/index counter across the design wherever a fixed 2^BITS up count is insufficient.

Parameters:
- BITS, 8, counter width; legal range 2..32.
- SATURATE, 0, boundary mode: 0 = wrap, 1 = saturate (hold at boundary).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en is high.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- d  input  BITS  load value.
- max_val  input  BITS  inclusive upper bound; modulus = max_val+1; may change at any time.
- Q  output  BITS  current count (registered).
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky boundary flag; cleared only by clr or reset.

Behaviour:
- Reset: reset_n low asynchronously forces Q=0, tc=0, ovf=0, independent of clk. Release is synchronised externally; first update occurs on the first rising edge with reset_n high.
- Command priority per edge: clr > load > en > hold. All commands are sampled on the rising edge; the result is visible on Q after that same edge (latency 1).
- clr: Q=0, tc=0, ovf=0.
- load: Q = d if d <= max_val, otherwise Q = max_val. tc=0; ovf unchanged.
- en & up, Q < max_val: Q = Q+1, tc=0.
- en & up, Q >= max_val (boundary):
  - Wrap mode: Q=0.
  - Saturate mode: Q=max_val.
  - Either mode: tc=1, ovf=1.
- en & ~up, Q > max_val (max_val lowered at runtime): Q = max_val, tc=0. Not a boundary event.
- en & ~up, 0 < Q <= max_val: Q = Q-1, tc=0.
- en & ~up, Q == 0 (boundary):
  - Wrap mode: Q = max_val.
  - Saturate mode: Q=0.
  - Either mode: tc=1, ovf=1.
- Hold (no command): Q unchanged, tc=0.
- tc is high in exactly the cycle Q shows the post-boundary value. Back-to-back boundary steps give tc high on consecutive cycles, e.g. max_val=0 with en high, or saturate mode held at the bound.
- Arithmetic is BITS wide, unsigned; no carry leaks. With max_val = 2^BITS-1 in wrap mode, behaviour matches a plain modulo-2^BITS counter.
- Direction change takes effect on the same edge it is sampled; no turnaround cycle.
- reset_n asserted mid-count aborts immediately; no partial update is retained.

Decomposition:
- Shared package: mode constants MODE_WRAP=0 and MODE_SAT=1; a function for the clamped load value. Nothing else is shared.
- One natural sub-module: mod_counter_next. It is purely combinational: (Q, up, max_val, SATURATE) -> (next_q, boundary).
- The top holds the Q/tc/ovf registers and command priority.

Test Plan:
- Reset during count: BITS=4, max_val=9, count to 5, pulse reset_n low between edges -> Q=0, tc=0, ovf=0 immediately, without waiting for an edge.
- Wrap up: max_val=9, en=1, up=1 from 0 -> Q runs 0..9,0. tc high only in the cycle Q=0 after 9. ovf=1 and stays high.
- Down wrap / saturate: from Q=0 with max_val=9, en=1, up=0:
  - SATURATE=0 -> Q=9, tc=1.
  - SATURATE=1 -> Q stays 0, tc high every enabled cycle.
- Load clamp and priority:
  - load=1, d=12, max_val=9 -> Q=9.
  - clr=1 and load=1 on the same edge -> Q=0, ovf=0.
  - load=1 and en=1 with d=3 -> Q=3 (no step).
- Runtime max_val change: Q=8, set max_val=5:
  - Up step -> boundary: wrap gives Q=0, tc=1; saturate gives Q=5.
  - Down step -> Q=5, tc=0.
- Full range and degenerate modulus:
  - BITS=4, max_val=15, wrap, up -> 15 then 0 with tc=1, matching modulo-16.
  - max_val=0, en=1 -> Q stays 0, tc=1 every cycle.
